// File: rtl/wts_channel_mixer.sv
// wts_channel_mixer
// Sums the enabled channels of each time-multiplexed frame of signed 8-bit
// samples and presents one signed mixed sample per completed frame.
// Optional feature macro: WTS_MIXER_LPF_EN. When defined, each new output is
// the average of the previous output and the new frame sum, using an
// arithmetic shift that rounds toward -inf.
// The frame sum is kept at full precision and is never clipped.

module wts_channel_mixer #(
    parameter int NUM_CH = 5,
    parameter int MIX_W  = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame_start,
    input  logic                     channel_valid,
    input  logic signed [7:0]        channel,
    input  logic [NUM_CH-1:0]        reg_channel_mask,
    output logic signed [MIX_W-1:0]  mix_out,
    output logic                     mix_valid,
    output logic                     frame_err
);

    // Width of the accumulator. Its range always covers NUM_CH * [-128, 127].
    localparam int ACC_W  = 8 + $clog2(NUM_CH);
    // Width of the slot index. It must also hold the idle value NUM_CH.
    localparam int SLOT_W = $clog2(NUM_CH + 1);
    localparam logic [SLOT_W-1:0] SLOT_IDLE = SLOT_W'(NUM_CH);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_CH - 1);
    localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);

    // Reject configurations the datapath cannot represent.
    generate
        if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
            $error("wts_channel_mixer: NUM_CH must be in 2..8");
        end
        if (MIX_W < ACC_W) begin : g_bad_mix_w
            $error("wts_channel_mixer: MIX_W must be >= 8+clog2(NUM_CH)");
        end
    endgenerate

    // Registered state.
    logic [SLOT_W-1:0]        slot_r;
    logic signed [ACC_W-1:0]  acc_r;
    logic signed [MIX_W-1:0]  mix_out_r;
    logic                     mix_valid_r;
    logic                     frame_err_r;

    // Combinational datapath.
    logic [SLOT_W-1:0]        slot_idx_s;
    logic                     mask_bit_s;
    logic signed [ACC_W-1:0]  term_s;
    logic signed [ACC_W-1:0]  acc_sum_s;
    logic signed [MIX_W-1:0]  result_s;
`ifdef WTS_MIXER_LPF_EN
    logic signed [MIX_W:0]    lpf_sum_s;
`endif

    // Select this beat's mask bit and term, and form the running sum and the next output value.
    always_comb begin
        // A frame_start beat is always slot 0, whatever slot the counter holds.
        slot_idx_s = frame_start ? '0 : slot_r;
        mask_bit_s = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            mask_bit_s = mask_bit_s | (reg_channel_mask[i] & (slot_idx_s == SLOT_W'(i)));
        end
        term_s    = mask_bit_s ? ACC_W'(channel) : '0;
        acc_sum_s = acc_r + term_s;
`ifdef WTS_MIXER_LPF_EN
        // Compute one bit wider so the average of two MIX_W values cannot overflow.
        lpf_sum_s = (MIX_W + 1)'(mix_out_r) + (MIX_W + 1)'(acc_sum_s);
        result_s  = lpf_sum_s[MIX_W:1];
`else
        result_s  = MIX_W'(acc_sum_s);
`endif
    end

    // Track the slot, accumulate terms, and emit the mix and framing-error pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_r      <= SLOT_IDLE;
            acc_r       <= '0;
            mix_out_r   <= '0;
            mix_valid_r <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            mix_valid_r <= 1'b0;
            frame_err_r <= 1'b0;
            if (channel_valid) begin
                if (frame_start) begin
                    // A restart before the last slot discards the partial frame.
                    acc_r       <= term_s;
                    slot_r      <= SLOT_ONE;
                    frame_err_r <= (slot_r != SLOT_IDLE);
                end else if (slot_r == SLOT_IDLE) begin
                    // A sample arrived with no open frame, so it is dropped.
                    frame_err_r <= 1'b1;
                end else if (slot_r == SLOT_LAST) begin
                    acc_r       <= acc_sum_s;
                    mix_out_r   <= result_s;
                    mix_valid_r <= 1'b1;
                    slot_r      <= SLOT_IDLE;
                end else begin
                    acc_r       <= acc_sum_s;
                    slot_r      <= slot_r + SLOT_ONE;
                end
            end
        end
    end

    assign mix_out   = mix_out_r;
    assign mix_valid = mix_valid_r;
    assign frame_err = frame_err_r;

endmodule
